// File: rtl/parking_occupancy_counter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | parking_pkg                                                                |
// | Shared gate FSM state type and popcount helper for the occupancy counter.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package parking_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        IN_A     = 3'd1,
        IN_B     = 3'd2,
        IN_C     = 3'd3,
        OUT_A    = 3'd4,
        OUT_B    = 3'd5,
        OUT_C    = 3'd6,
        WAIT_CLR = 3'd7
    } gate_state_t;

    // Sized for the largest supported gate count (8).
    function automatic logic [3:0] popcount(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/parking_occupancy_counter_gate_direction_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gate_direction_fsm                                                         |
// | One gate: debounces S1/S2 and decodes the pair into entry/exit pulses.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module gate_direction_fsm
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic s1,
    input  logic s2,
    output logic entering,
    output logic exiting
);

    localparam int              c_dw   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_dw-1:0] c_last = c_dw'(DEBOUNCE_CYCLES - 1);

    logic [1:0]  w_raw;
    logic [1:0]  w_filt;
    gate_state_t r_state;
    gate_state_t w_next;
    logic        w_enter;
    logic        w_exit;
    logic        r_enter;
    logic        r_exit;

    assign w_raw = {s1, s2};

    for (genvar k = 0; k < 2; k++) begin : g_deb
        logic [c_dw-1:0] r_cnt;
        logic            r_lvl;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_cnt <= '0;
                r_lvl <= 1'b0;
            end else if (w_raw[k] == r_lvl) begin
                r_cnt <= '0;
            end else if (r_cnt == c_last) begin
                r_cnt <= '0;
                r_lvl <= w_raw[k];
            end else begin
                r_cnt <= r_cnt + c_dw'(1);
            end
        end

        assign w_filt[k] = r_lvl;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_enter <= 1'b0;
            r_exit  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_enter <= w_enter;
            r_exit  <= w_exit;
        end
    end

    // Pattern order is {S1,S2}; OUT_* mirror IN_* with the sensors swapped.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_filt == 2'b10)      w_next = IN_A;
                else if (w_filt == 2'b01) w_next = OUT_A;
                else if (w_filt == 2'b11) w_next = WAIT_CLR;
            end
            IN_A: begin
                if (w_filt == 2'b11)      w_next = IN_B;
                else if (w_filt == 2'b00) w_next = IDLE;
                else if (w_filt == 2'b01) w_next = WAIT_CLR;
            end
            IN_B: begin
                if (w_filt == 2'b01)      w_next = IN_C;
                else if (w_filt == 2'b10) w_next = IN_A;
                else if (w_filt == 2'b00) w_next = WAIT_CLR;
            end
            IN_C: begin
                if (w_filt == 2'b00)      w_next = IDLE;
                else if (w_filt == 2'b11) w_next = IN_B;
                else if (w_filt == 2'b10) w_next = WAIT_CLR;
            end
            OUT_A: begin
                if (w_filt == 2'b11)      w_next = OUT_B;
                else if (w_filt == 2'b00) w_next = IDLE;
                else if (w_filt == 2'b10) w_next = WAIT_CLR;
            end
            OUT_B: begin
                if (w_filt == 2'b10)      w_next = OUT_C;
                else if (w_filt == 2'b01) w_next = OUT_A;
                else if (w_filt == 2'b00) w_next = WAIT_CLR;
            end
            OUT_C: begin
                if (w_filt == 2'b00)      w_next = IDLE;
                else if (w_filt == 2'b11) w_next = OUT_B;
                else if (w_filt == 2'b01) w_next = WAIT_CLR;
            end
            WAIT_CLR: begin
                if (w_filt == 2'b00)      w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_enter = (r_state == IN_C)  && (w_filt == 2'b00);
        w_exit  = (r_state == OUT_C) && (w_filt == 2'b00);
    end

    assign entering = r_enter;
    assign exiting  = r_exit;

endmodule
`default_nettype wire

// File: rtl/parking_occupancy_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | parking_occupancy_counter                                                  |
// | Multi-gate occupancy counter: per-gate direction decode, saturating merge. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module parking_occupancy_counter
    import parking_pkg::*;
#(
    parameter  int N_GATES         = 2,
    parameter  int CAPACITY        = 99,
    parameter  int DEBOUNCE_CYCLES = 16,
    localparam int CW              = $clog2(CAPACITY + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_GATES-1:0] s1,
    input  logic [N_GATES-1:0] s2,
    output logic [CW-1:0]      count,
    output logic               full,
    output logic               empty,
    output logic [N_GATES-1:0] entering,
    output logic [N_GATES-1:0] exiting,
    output logic               reject_full,
    output logic               reject_empty
);

    localparam int                     c_sw     = CW + $clog2(N_GATES) + 2;
    localparam logic signed [c_sw-1:0] c_cap_sw = c_sw'(CAPACITY);
    localparam logic [CW-1:0]          c_cap    = CW'(CAPACITY);

    logic [3:0]             w_pop_e;
    logic [3:0]             w_pop_x;
    logic signed [c_sw-1:0] w_cnt_ext;
    logic signed [c_sw-1:0] w_e;
    logic signed [c_sw-1:0] w_x;
    logic signed [c_sw-1:0] w_sum;
    logic [CW-1:0]          w_next;
    logic                   w_rej_full;
    logic                   w_rej_empty;

    for (genvar g = 0; g < N_GATES; g++) begin : g_gate
        gate_direction_fsm #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_gate (
            .clk      (clk),
            .reset    (reset),
            .s1       (s1[g]),
            .s2       (s2[g]),
            .entering (entering[g]),
            .exiting  (exiting[g])
        );
    end

    // Net change is applied once, so simultaneous +1/-1 cancel before clamping.
    always_comb begin
        w_pop_e     = popcount(8'(entering));
        w_pop_x     = popcount(8'(exiting));
        w_e         = c_sw'(w_pop_e);
        w_x         = c_sw'(w_pop_x);
        w_cnt_ext   = c_sw'(count);
        w_sum       = w_cnt_ext + w_e - w_x;
        w_rej_full  = 1'b0;
        w_rej_empty = 1'b0;
        if (w_sum > c_cap_sw) begin
            w_next     = c_cap;
            w_rej_full = 1'b1;
        end else if (w_sum[c_sw-1]) begin
            w_next      = '0;
            w_rej_empty = 1'b1;
        end else begin
            w_next = w_sum[CW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            reject_full  <= 1'b0;
            reject_empty <= 1'b0;
        end else begin
            count        <= w_next;
            full         <= (w_next == c_cap);
            empty        <= (w_next == '0);
            reject_full  <= w_rej_full;
            reject_empty <= w_rej_empty;
        end
    end

endmodule
`default_nettype wire
